jtag_bitbang_bridge: RTL and testbench



---
 rtl/jtag_bitbang_bridge_if.sv | 22 ++
 rtl/jtag_bitbang_bridge.sv | 227 ++++++++++++++++++++++
 tb/tb_jtag_bitbang_bridge.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/jtag_bitbang_bridge_if.sv
// UART-side byte streams of the remote_bitbang bridge: the command byte
// stream in (rx_*) and the TDO response byte stream out (tx_*).
interface jtag_bitbang_bridge_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    // Byte source / response sink side (UART)
    modport master (
        output rx_valid, rx_data, tx_ready,
        input  rx_ready, tx_valid, tx_data
    );

    // Bridge side
    modport slave (
        input  rx_valid, rx_data, tx_ready,
        output rx_ready, tx_valid, tx_data
    );
endinterface

// File: rtl/jtag_bitbang_bridge.sv
// OpenOCD remote_bitbang command decoder driving JTAG and reset pins.
// Each accepted byte becomes a short micro-op sequence.
// Every pin update is held for HOLD_CYCLES clocks.
// 'R' responses go through a small FIFO.
// Unsupported bytes set a sticky err flag and bump a saturating counter.
// Define BITBANG_PACKED_EN to decode the packed commands ')!@#' and '$%^&'.
module jtag_bitbang_bridge #(
    parameter int unsigned HOLD_CYCLES = 8,
    parameter int unsigned RESP_DEPTH  = 4,
    parameter int unsigned ERR_W       = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    jtag_bitbang_bridge_if.slave bus,
    output logic                 jtag_tck,
    output logic                 jtag_tms,
    output logic                 jtag_tdi,
    input  logic                 jtag_tdo,
    output logic                 jtag_trst_n,
    output logic                 jtag_srst_n,
    output logic                 led,
    output logic                 quit,
    output logic                 err,
    output logic [ERR_W-1:0]     err_cnt
);

`ifdef BITBANG_PACKED_EN
    localparam int unsigned SEQ_LEN = 3;
`else
    localparam int unsigned SEQ_LEN = 1;
`endif
    localparam int unsigned HCW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned PW  = $clog2(RESP_DEPTH);
    localparam int unsigned CW  = PW + 1;

    typedef enum logic [2:0] {OP_PIN, OP_RST, OP_LED, OP_READ, OP_QUIT} op_kind_e;
    typedef struct packed {
        op_kind_e   kind;
        logic [2:0] arg;
    } op_t;
    typedef op_t [SEQ_LEN-1:0] seq_t;
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_HOLD} state_e;

    state_e          state;
    seq_t            seq;
    logic [1:0]      n_left;
    logic [HCW-1:0]  hcnt;
    logic            rdy;

    seq_t            dec_seq;
    logic [1:0]      dec_n;
    logic            dec_ok;
    logic            accept;

    logic [7:0]      mem [RESP_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [CW-1:0]   cnt;
    logic            stg_v;
    logic            stg_d;
    logic            push;
    logic            pop;

    function automatic op_t mk_op(input op_kind_e kind, input logic [2:0] arg);
        op_t o;
        o.kind = kind;
        o.arg  = arg;
        return o;
    endfunction

    // Drop the head op; the tail fills with a don't-care PIN op.
    function automatic seq_t shift_seq(input seq_t s);
        seq_t r;
        r = '0;
        for (int unsigned i = 0; i + 1 < SEQ_LEN; i++) r[i] = s[i+1];
        return r;
    endfunction

    assign bus.rx_ready = rdy;
    assign accept       = rdy && bus.rx_valid;
    assign bus.tx_valid = (cnt != '0);
    assign bus.tx_data  = mem[rd_ptr];
    assign pop          = bus.tx_valid && bus.tx_ready;

    // The staged entry already holds a slot, so it counts toward occupancy.
    assign push = (state == S_EXEC) && (seq[0].kind == OP_READ) &&
                  (((cnt + CW'(stg_v)) < CW'(RESP_DEPTH)) || pop);

    // Translate the incoming command byte into its micro-op sequence
    always_comb begin
        dec_ok  = 1'b1;
        dec_n   = 2'd1;
        dec_seq = '0;
        case (bus.rx_data)
            "0", "1", "2", "3", "4", "5", "6", "7":
                dec_seq[0] = mk_op(OP_PIN, bus.rx_data[2:0]);
            "r": dec_seq[0] = mk_op(OP_RST, 3'd0);
            "s": dec_seq[0] = mk_op(OP_RST, 3'd1);
            "t": dec_seq[0] = mk_op(OP_RST, 3'd2);
            "u": dec_seq[0] = mk_op(OP_RST, 3'd3);
            "B": dec_seq[0] = mk_op(OP_LED, 3'd1);
            "b": dec_seq[0] = mk_op(OP_LED, 3'd0);
            "R": dec_seq[0] = mk_op(OP_READ, 3'd0);
            "Q": dec_seq[0] = mk_op(OP_QUIT, 3'd0);
`ifdef BITBANG_PACKED_EN
            ")", "!", "@", "#": begin
                dec_n = 2'd2;
                case (bus.rx_data)
                    ")":     dec_seq[0] = mk_op(OP_PIN, 3'd0);
                    "!":     dec_seq[0] = mk_op(OP_PIN, 3'd1);
                    "@":     dec_seq[0] = mk_op(OP_PIN, 3'd2);
                    default: dec_seq[0] = mk_op(OP_PIN, 3'd3);
                endcase
                dec_seq[1] = mk_op(OP_PIN, dec_seq[0].arg | 3'd4);
            end
            "$", "%", "^", "&": begin
                dec_n = 2'd3;
                case (bus.rx_data)
                    "$":     dec_seq[0] = mk_op(OP_PIN, 3'd0);
                    "%":     dec_seq[0] = mk_op(OP_PIN, 3'd1);
                    "^":     dec_seq[0] = mk_op(OP_PIN, 3'd2);
                    default: dec_seq[0] = mk_op(OP_PIN, 3'd3);
                endcase
                dec_seq[1] = mk_op(OP_READ, 3'd0);
                dec_seq[2] = mk_op(OP_PIN, dec_seq[0].arg | 3'd4);
            end
`endif
            default: dec_ok = 1'b0;
        endcase
    end

    // Sequencer: accept, execute head op, hold, with registered pin outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            seq         <= '0;
            n_left      <= '0;
            hcnt        <= '0;
            rdy         <= 1'b0;
            jtag_tck    <= 1'b0;
            jtag_tms    <= 1'b0;
            jtag_tdi    <= 1'b0;
            jtag_trst_n <= 1'b1;
            jtag_srst_n <= 1'b1;
            led         <= 1'b0;
            quit        <= 1'b0;
            err         <= 1'b0;
            err_cnt     <= '0;
        end else begin
            quit <= 1'b0;
            case (state)
                S_IDLE: begin
                    rdy <= 1'b1;
                    if (accept) begin
                        if (dec_ok) begin
                            seq    <= dec_seq;
                            n_left <= dec_n;
                            state  <= S_EXEC;
                            rdy    <= 1'b0;
                        end else begin
                            err <= 1'b1;
                            if (err_cnt != '1) err_cnt <= err_cnt + ERR_W'(1);
                        end
                    end
                end
                S_EXEC: begin
                    if (seq[0].kind == OP_READ) begin
                        if (push) begin
                            seq    <= shift_seq(seq);
                            n_left <= n_left - 2'd1;
                            if (n_left == 2'd1) begin
                                state <= S_IDLE;
                                rdy   <= 1'b1;
                            end
                        end
                    end else begin
                        case (seq[0].kind)
                            OP_PIN:  {jtag_tck, jtag_tms, jtag_tdi} <= seq[0].arg;
                            OP_RST:  {jtag_trst_n, jtag_srst_n} <= seq[0].arg[1:0];
                            OP_LED:  led <= seq[0].arg[0];
                            OP_QUIT: quit <= 1'b1;
                            default: ;
                        endcase
                        seq    <= shift_seq(seq);
                        n_left <= n_left - 2'd1;
                        hcnt   <= HCW'(HOLD_CYCLES - 1);
                        state  <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (hcnt == '0) begin
                        if (n_left != 2'd0) begin
                            state <= S_EXEC;
                        end else begin
                            state <= S_IDLE;
                            rdy   <= 1'b1;
                        end
                    end else begin
                        hcnt <= hcnt - 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Response FIFO: a push is staged one clock before it becomes visible
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            stg_v  <= 1'b0;
            stg_d  <= 1'b0;
        end else begin
            stg_v <= push;
            stg_d <= jtag_tdo;
            if (stg_v) begin
                mem[wr_ptr] <= {7'b0011000, stg_d};
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            cnt <= cnt + CW'(stg_v) - CW'(pop);
        end
    end

endmodule

// File: tb/tb_jtag_bitbang_bridge.sv
// Directed bench for jtag_bitbang_bridge (HOLD_CYCLES=8, RESP_DEPTH=4, ERR_W=8).
// The packed-command scenario follows BITBANG_PACKED_EN.
module tb_jtag_bitbang_bridge;
    logic       clk = 1'b0;
    logic       rst;
    logic       jtag_tdo;
    logic       tck, tms, tdi, trst_n, srst_n, led, quit, err;
    logic [7:0] err_cnt;
    int         n_cmp = 0;
    int         n_bad = 0;

    jtag_bitbang_bridge_if bus();

    jtag_bitbang_bridge #(.HOLD_CYCLES(8), .RESP_DEPTH(4), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .bus(bus),
        .jtag_tck(tck), .jtag_tms(tms), .jtag_tdi(tdi), .jtag_tdo(jtag_tdo),
        .jtag_trst_n(trst_n), .jtag_srst_n(srst_n),
        .led(led), .quit(quit), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at 2ms, required finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input logic [7:0] b);
        logic done;
        done = 1'b0;
        @(negedge clk);
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        for (int k = 0; k < 100 && !done; k++) begin
            if (bus.rx_ready) begin
                @(posedge clk);
                done = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 bus.rx_valid = 1'b0;
        if (!done) begin
            n_cmp++; n_bad++;
            $display("FAIL send_timeout: byte %h not accepted, required acceptance within 100 cycles", b);
        end
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus.rx_ready) break;
        end
        n_cmp++;
        if (bus.rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL idle_timeout: rx_ready=%b, required 1 within 100 cycles", bus.rx_ready);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1; bus.rx_valid = 1'b0; bus.tx_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [17:0] got;
        rst = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0; jtag_tdo = 1'b0;
        repeat (3) @(negedge clk);
        got = {bus.rx_ready, tck, tms, tdi, trst_n, srst_n, led, quit, err, bus.tx_valid, err_cnt};
        n_cmp++;
        if (got !== {10'b0000110000, 8'h00}) begin
            n_bad++;
            $display("FAIL reset_values: got %b, required %b", got, {10'b0000110000, 8'h00});
        end
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: rx_ready=%b, required 1", bus.rx_ready);
        end
    endtask

    task automatic test_pin();
        int lows;
        send("5");
        @(negedge clk);
        n_cmp++;
        if ({tck, tms, tdi} !== 3'b000) begin
            n_bad++; $display("FAIL pin_before_edge: pins=%b, required 000", {tck, tms, tdi});
        end
        lows = bus.rx_ready ? 0 : 1;
        @(negedge clk);
        n_cmp++;
        if ({tck, tms, tdi} !== 3'b101) begin
            n_bad++; $display("FAIL pin_after_edge: pins=%b, required 101", {tck, tms, tdi});
        end
        if (!bus.rx_ready) lows++;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.rx_ready) break;
            lows++;
        end
        n_cmp++;
        if (lows != 9) begin
            n_bad++; $display("FAIL pin_busy_cycles: rx_ready low %0d cycles, required 9", lows);
        end
    endtask

    task automatic test_read_fifo();
        logic [7:0] exp_data [4];
        exp_data[0] = 8'h31; exp_data[1] = 8'h31; exp_data[2] = 8'h31; exp_data[3] = 8'h30;
        apply_reset();
        jtag_tdo = 1'b1;
        send("R");
        @(negedge clk);
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin
            n_bad++; $display("FAIL read_valid_n0: tx_valid=%b, required 0", bus.tx_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin
            n_bad++; $display("FAIL read_valid_n1: tx_valid=%b, required 0", bus.tx_valid);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h31) begin
            n_bad++; $display("FAIL read_valid_n2: tx_valid=%b tx_data=%h, required 1/31", bus.tx_valid, bus.tx_data);
        end
        repeat (4) send("R");
        repeat (6) @(negedge clk);
        n_cmp++;
        if (bus.rx_ready !== 1'b0 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h31) begin
            n_bad++;
            $display("FAIL read_full_stall: rx_ready=%b tx_valid=%b tx_data=%h, required 0/1/31",
                     bus.rx_ready, bus.tx_valid, bus.tx_data);
        end
        @(negedge clk);
        jtag_tdo = 1'b0; bus.tx_ready = 1'b1;
        @(posedge clk); #1 bus.tx_ready = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rx_ready !== 1'b1) begin
            n_bad++; $display("FAIL read_unstall: rx_ready=%b, required 1", bus.rx_ready);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_cmp++;
            if (bus.tx_valid !== 1'b1 || bus.tx_data !== exp_data[i]) begin
                n_bad++;
                $display("FAIL read_drain_%0d: tx_valid=%b tx_data=%h, required 1/%h",
                         i, bus.tx_valid, bus.tx_data, exp_data[i]);
            end
            bus.tx_ready = 1'b1;
            @(posedge clk); #1 bus.tx_ready = 1'b0;
        end
        @(negedge clk);
        n_cmp++;
        if (bus.tx_valid !== 1'b0) begin
            n_bad++; $display("FAIL read_empty: tx_valid=%b, required 0", bus.tx_valid);
        end
    endtask

    task automatic test_cmds();
        int qc;
        send("t");
        wait_idle();
        n_cmp++;
        if ({trst_n, srst_n} !== 2'b10) begin
            n_bad++; $display("FAIL rst_cmd_t: trst_n,srst_n=%b, required 10", {trst_n, srst_n});
        end
        send("B");
        wait_idle();
        n_cmp++;
        if (led !== 1'b1) begin
            n_bad++; $display("FAIL led_on: led=%b, required 1", led);
        end
        send("Q");
        qc = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (quit === 1'b1) qc++;
        end
        n_cmp++;
        if (qc != 1) begin
            n_bad++; $display("FAIL quit_pulse: quit high %0d cycles, required 1", qc);
        end
    endtask

    task automatic test_err();
        apply_reset();
        send("6");
        wait_idle();
        n_cmp++;
        if (err !== 1'b0 || err_cnt !== 8'd0) begin
            n_bad++; $display("FAIL err_clear: err=%b err_cnt=%0d, required 0/0", err, err_cnt);
        end
        repeat (3) send(8'h7A);
        @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || err_cnt !== 8'd3 || {tck, tms, tdi} !== 3'b110 || bus.rx_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL err_three: err=%b err_cnt=%0d pins=%b rx_ready=%b, required 1/3/110/1",
                     err, err_cnt, {tck, tms, tdi}, bus.rx_ready);
        end
        repeat (260) send(8'h7A);
        @(negedge clk);
        n_cmp++;
        if (err_cnt !== 8'hFF) begin
            n_bad++; $display("FAIL err_saturate: err_cnt=%h, required ff", err_cnt);
        end
    endtask

    task automatic test_packed();
        apply_reset();
        jtag_tdo = 1'b0;
        send("%");
`ifdef BITBANG_PACKED_EN
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({tck, tms, tdi} !== 3'b001) begin
            n_bad++; $display("FAIL packed_first_pin: pins=%b, required 001", {tck, tms, tdi});
        end
        repeat (9) @(negedge clk);
        n_cmp++;
        if ({tck, tms, tdi} !== 3'b001 || bus.tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL packed_hold: pins=%b tx_valid=%b, required 001/0", {tck, tms, tdi}, bus.tx_valid);
        end
        @(negedge clk);
        n_cmp++;
        if ({tck, tms, tdi} !== 3'b101 || bus.tx_valid !== 1'b1 || bus.tx_data !== 8'h30) begin
            n_bad++;
            $display("FAIL packed_read_pin: pins=%b tx_valid=%b tx_data=%h, required 101/1/30",
                     {tck, tms, tdi}, bus.tx_valid, bus.tx_data);
        end
        wait_idle();
`else
        repeat (2) @(negedge clk);
        n_cmp++;
        if (err !== 1'b1 || err_cnt !== 8'd1 || {tck, tms, tdi} !== 3'b000 ||
            bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL packed_unsupported: err=%b err_cnt=%0d pins=%b rx_ready=%b tx_valid=%b, required 1/1/000/1/0",
                     err, err_cnt, {tck, tms, tdi}, bus.rx_ready, bus.tx_valid);
        end
`endif
    endtask

    task automatic test_rst_in_hold();
        logic [17:0] got;
        apply_reset();
        jtag_tdo = 1'b1;
        send(8'h7A);
        send("B");
        send("s");
        send("R");
        send("R");
        send("7");
        repeat (4) @(negedge clk);
        n_cmp++;
        if (bus.tx_valid !== 1'b1 || {tck, tms, tdi} !== 3'b111 || err !== 1'b1 || led !== 1'b1 ||
            bus.rx_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL hold_precondition: tx_valid=%b pins=%b err=%b led=%b rx_ready=%b, required 1/111/1/1/0",
                     bus.tx_valid, {tck, tms, tdi}, err, led, bus.rx_ready);
        end
        rst = 1'b1;
        @(posedge clk); #1;
        got = {bus.rx_ready, tck, tms, tdi, trst_n, srst_n, led, quit, err, bus.tx_valid, err_cnt};
        n_cmp++;
        if (got !== {10'b0000110000, 8'h00}) begin
            n_bad++; $display("FAIL rst_in_hold: got %b, required %b", got, {10'b0000110000, 8'h00});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (bus.rx_ready !== 1'b1 || bus.tx_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_in_hold_release: rx_ready=%b tx_valid=%b, required 1/0", bus.rx_ready, bus.tx_valid);
        end
    endtask

    initial begin
        test_reset();
        test_pin();
        test_read_fifo();
        test_cmds();
        test_err();
        test_packed();
        test_rst_in_hold();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
